// File: rtl/oscope_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : oscope_pkg
//  Description : Shared types for the oscilloscope trigger/capture engine:
//                trigger edge selection, capture state encoding, sample type
//                and edge-decode helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package oscope_pkg;

  localparam int c_DW_DEFAULT = 8;

  // Edge selection; code 3 is reserved and behaves as RISE
  typedef enum logic [1:0] {
    RISE = 2'd0,
    FALL = 2'd1,
    BOTH = 2'd2
  } trig_edge_e;

  // Capture engine states
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    ARM  = 3'd2,
    POST = 3'd3,
    DONE = 3'd4
  } cap_state_e;

  typedef logic signed [c_DW_DEFAULT-1:0] sample_t;

  // Rising detector participates for RISE, BOTH and the reserved code
  function automatic logic edge_uses_rise(input logic [1:0] sel);
    return (sel != FALL);
  endfunction

  // Falling detector participates for FALL and BOTH only
  function automatic logic edge_uses_fall(input logic [1:0] sel);
    return (sel == FALL) || (sel == BOTH);
  endfunction

endpackage
`default_nettype wire

// File: rtl/oscope_smp_ram.sv
`default_nettype none
// ============================================================================
//  Module      : oscope_smp_ram
//  Description : Simple dual-port sample RAM, DEPTH x DW. One write port, one
//                read port with a registered output (1-cycle read latency).
//                The output register only updates on a read so it holds.
//  Revision    : 1.0 - initial release
// ============================================================================
module oscope_smp_ram #(
  parameter int DW    = 8,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_wa,
  input  logic [DW-1:0] i_wd,
  input  logic          i_re,
  input  logic [AW-1:0] i_ra,
  output logic [DW-1:0] o_rd
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_q;

  // Sample storage write port
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_wa] <= i_wd;
  end

  // Registered read port; cleared by reset so the readout bus starts at zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      r_q <= '0;
    else if (i_re) r_q <= r_mem[i_ra];
  end

  assign o_rd = r_q;

endmodule
`default_nettype wire

// File: rtl/oscope_trig_capture.sv
`default_nettype none
// ============================================================================
//  Module      : oscope_trig_capture
//  Description : Oscilloscope trigger/capture engine. Writes en-qualified
//                samples into a circular RAM, detects edge crossings of a
//                level with hysteresis (or forces a trigger on timeout), and
//                serves the LEN-sample record back in time order.
//  Revision    : 1.0 - initial release
// ============================================================================
module oscope_trig_capture
  import oscope_pkg::*;
#(
  parameter int DW    = 8,
  parameter int LEN   = 1000,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH),
  parameter int TOW   = 27
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] din,
  input  logic                 en,
  input  logic                 start,
  input  logic [1:0]           edge_sel,
  input  logic signed [DW-1:0] level,
  input  logic [DW-1:0]        hyst,
  input  logic [AW-1:0]        hpos,
  input  logic [TOW-1:0]       to,
  input  logic                 rd,
  output logic signed [DW-1:0] dout,
  output logic                 dout_vld,
  output logic                 busy,
  output logic                 done,
  output logic                 trig_flag
);

  // Two guard bits keep level +/- hyst exact over the full input ranges
  localparam int              c_CW     = DW + 2;
  localparam logic [AW-1:0]   c_LEN_M1 = AW'(LEN - 1);
  localparam logic [AW:0]     c_LEN_RD = (AW+1)'(LEN);

  cap_state_e             r_state, w_state_nxt;
  logic [AW-1:0]          r_wa, r_hp, r_cnt, r_taddr, r_rd_addr;
  logic [AW-1:0]          w_hp_clamp, w_post_len, w_cnt_inc, w_taddr;
  logic [AW:0]            r_rd_cnt;
  logic [TOW-1:0]         r_tmo_cnt;
  logic                   r_rise_arm, r_fall_arm, r_trig_flag, r_dout_vld;
  logic signed [c_CW-1:0] w_x, w_lv, w_hy, w_lo, w_hi;
  logic                   w_rise_hit, w_fall_hit, w_lvl_trig, w_tmo, w_trig;
  logic                   w_wr, w_rd_ok;
  logic [DW-1:0]          w_ram_q;

  assign w_x  = {{2{din[DW-1]}}, din};
  assign w_lv = {{2{level[DW-1]}}, level};
  assign w_hy = {2'b00, hyst};
  assign w_lo = w_lv - w_hy;
  assign w_hi = w_lv + w_hy;

  assign w_rise_hit = r_rise_arm && (w_x >= w_lv);
  assign w_fall_hit = r_fall_arm && (w_x <= w_lv);
  assign w_lvl_trig = (edge_uses_rise(edge_sel) && w_rise_hit) ||
                      (edge_uses_fall(edge_sel) && w_fall_hit);
  // Timeout counts clk cycles spent in ARM; to == 0 disables it
  assign w_tmo      = (to != '0) && (r_tmo_cnt >= to);
  // A level hit and a timeout on the same sample both trigger; the flag
  // records the level hit, so the level trigger takes precedence
  assign w_trig     = (r_state == ARM) && en && !start && (w_lvl_trig || w_tmo);

  assign w_hp_clamp = (hpos > c_LEN_M1) ? c_LEN_M1 : hpos;
  assign w_post_len = c_LEN_M1 - r_hp;
  assign w_cnt_inc  = r_cnt + AW'(1);
  // On an ARM->DONE jump the trigger address is still the live write pointer
  assign w_taddr    = (r_state == ARM) ? r_wa : r_taddr;

  // Capture state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state, write/read strobes and status outputs
  always_comb begin
    w_state_nxt = r_state;
    w_wr        = 1'b0;
    w_rd_ok     = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
      end
      PRE: begin
        busy = 1'b1;
        if (en) begin
          w_wr = 1'b1;
          if (w_cnt_inc == r_hp) w_state_nxt = ARM;
        end
      end
      ARM: begin
        busy = 1'b1;
        if (en) w_wr = 1'b1;
        if (w_trig) w_state_nxt = (w_post_len == '0) ? DONE : POST;
      end
      POST: begin
        busy = 1'b1;
        if (en) begin
          w_wr = 1'b1;
          if (w_cnt_inc == w_post_len) w_state_nxt = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        w_rd_ok = rd && (r_rd_cnt != c_LEN_RD);
      end
      default: w_state_nxt = IDLE;
    endcase
    // start always wins: restart cleanly, with no stray write or read
    if (start) begin
      w_state_nxt = (w_hp_clamp == '0) ? ARM : PRE;
      w_wr        = 1'b0;
      w_rd_ok     = 1'b0;
    end
  end

  // Write pointer, phase counters, arm flags, timeout and trigger capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wa        <= '0;
      r_hp        <= '0;
      r_cnt       <= '0;
      r_taddr     <= '0;
      r_tmo_cnt   <= '0;
      r_rise_arm  <= 1'b0;
      r_fall_arm  <= 1'b0;
      r_trig_flag <= 1'b0;
    end else if (start) begin
      r_wa        <= '0;
      r_hp        <= w_hp_clamp;
      r_cnt       <= '0;
      r_tmo_cnt   <= '0;
      r_rise_arm  <= 1'b0;
      r_fall_arm  <= 1'b0;
      r_trig_flag <= 1'b0;
    end else begin
      if (w_wr) r_wa <= r_wa + AW'(1);
      if (r_state == PRE && en)
        r_cnt <= (w_cnt_inc == r_hp) ? '0 : w_cnt_inc;
      if (r_state == POST && en)
        r_cnt <= w_cnt_inc;
      if (r_state == ARM && r_tmo_cnt != '1)
        r_tmo_cnt <= r_tmo_cnt + TOW'(1);
      if (w_trig) begin
        r_rise_arm  <= 1'b0;
        r_fall_arm  <= 1'b0;
        r_taddr     <= r_wa;
        r_trig_flag <= w_lvl_trig;
        r_cnt       <= '0;
      end else if (r_state == ARM && en) begin
        if (w_x < w_lo) r_rise_arm <= 1'b1;
        if (w_x > w_hi) r_fall_arm <= 1'b1;
      end
    end
  end

  // Readout pointer, read count and dout_vld pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_addr  <= '0;
      r_rd_cnt   <= '0;
      r_dout_vld <= 1'b0;
    end else if (start) begin
      r_rd_cnt   <= '0;
      r_dout_vld <= 1'b0;
    end else begin
      r_dout_vld <= w_rd_ok;
      if (w_state_nxt == DONE && r_state != DONE)
        r_rd_addr <= w_taddr - r_hp;
      else if (w_rd_ok)
        r_rd_addr <= r_rd_addr + AW'(1);
      if (w_rd_ok) r_rd_cnt <= r_rd_cnt + (AW+1)'(1);
    end
  end

  oscope_smp_ram #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .i_we (w_wr),
    .i_wa (r_wa),
    .i_wd (din),
    .i_re (w_rd_ok),
    .i_ra (r_rd_addr),
    .o_rd (w_ram_q)
  );

  assign dout      = w_ram_q;
  assign dout_vld  = r_dout_vld;
  assign trig_flag = r_trig_flag;

endmodule
`default_nettype wire

// File: tb/tb_oscope_trig_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_oscope_trig_capture
//  Description : Self-checking bench for oscope_trig_capture. A sample-list
//                reference model predicts the record; a monitor compares
//                readout data against a scoreboard queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_oscope_trig_capture;
  localparam int DW = 8, LEN = 1000, DEPTH = 1024, AW = 10, TOW = 27;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic signed [DW-1:0] din = '0;
  logic                 en = 1'b0, start = 1'b0, rd = 1'b0;
  logic [1:0]           edge_sel = '0;
  logic signed [DW-1:0] level = '0;
  logic [DW-1:0]        hyst = '0;
  logic [AW-1:0]        hpos = '0;
  logic [TOW-1:0]       to = '0;
  logic signed [DW-1:0] dout;
  logic                 dout_vld, busy, done, trig_flag;

  always #5 clk = ~clk;

  oscope_trig_capture #(.DW(DW), .LEN(LEN), .DEPTH(DEPTH), .AW(AW), .TOW(TOW)) dut (
    .clk(clk), .rst(rst), .din(din), .en(en), .start(start), .edge_sel(edge_sel),
    .level(level), .hyst(hyst), .hpos(hpos), .to(to), .rd(rd), .dout(dout),
    .dout_vld(dout_vld), .busy(busy), .done(done), .trig_flag(trig_flag));

  int n_checks = 0, n_err = 0;
  int exp_q[$];
  int got[$];
  bit cyc_en[$];
  int cyc_din[$];
  int smp_n, amp, per;
  int cfg_hp, cfg_edge, cfg_level, cfg_hyst, cfg_to;
  int m_phase, m_flag, m_trig;
  int m_written[$];
  int mon_e;

  task automatic check(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: every dout_vld pops one expected readout sample
  always @(negedge clk) begin
    if (rst && dout_vld) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL readout_unexpected: got dout_vld=1 dout=%0d expected no valid", $signed(dout));
      end else begin
        mon_e = exp_q.pop_front();
        got.push_back(int'($signed(dout)));
        if (int'($signed(dout)) != mon_e) begin
          n_err++;
          $display("FAIL readout[%0d]: got %0d expected %0d", got.size() - 1, $signed(dout), mon_e);
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gen_sample(input int mode, output bit e, output int d);
    real ph;
    ph = 2.0 * 3.14159265 * smp_n / per;
    case (mode)
      0:       begin e = 1'b1; d = -128 + (smp_n % 256); end
      1:       begin e = ($urandom_range(9, 0) < 7); d = int'(50.0 * $sin(ph)); end
      2:       begin e = 1'b1; d = int'($urandom_range(4, 0)) - 2; end
      3:       begin e = ($urandom_range(9, 0) < 8); d = -5; end
      default: begin
        e = ($urandom_range(9, 0) < 8);
        d = int'(amp * $sin(ph)) + int'($urandom_range(6, 0)) - 3;
      end
    endcase
    if (d > 127)  d = 127;
    if (d < -128) d = -128;
    if (e) smp_n++;
  endtask

  task automatic set_cfg(input int edg, input int lvl, input int hy, input int hp, input int tmo);
    cfg_edge = edg; cfg_level = lvl; cfg_hyst = hy; cfg_to = tmo;
    edge_sel = edg[1:0]; level = lvl[DW-1:0]; hyst = hy[DW-1:0];
    hpos = hp[AW-1:0]; to = tmo[TOW-1:0];
    cfg_hp = (hp > LEN - 1) ? LEN - 1 : hp;
  endtask

  task automatic do_start();
    int r;
    r = int'($urandom_range(255, 0)) - 128;
    start = 1'b1; en = 1'b1; din = r[DW-1:0];
    tick();
    start = 1'b0; en = 1'b0;
    cyc_en.delete(); cyc_din.delete(); smp_n = 0;
  endtask

  task automatic drive_cycles(input int n, input int mode);
    bit e;
    int d;
    for (int i = 0; i < n; i++) begin
      gen_sample(mode, e, d);
      en = e; din = d[DW-1:0];
      cyc_en.push_back(e); cyc_din.push_back(d);
      tick();
    end
    en = 1'b0;
  endtask

  // Reference: walk the written sample list; phases 0 pre, 1 armed, 2 post, 3 complete
  task automatic run_model();
    int arm_start, post_n, x;
    bit rise, fall, lvl, tmo;
    bit use_r, use_f;
    use_r = (cfg_edge != 1);
    use_f = (cfg_edge == 1) || (cfg_edge == 2);
    m_written.delete();
    m_flag = 0; m_trig = -1; post_n = 0; rise = 0; fall = 0;
    m_phase   = (cfg_hp == 0) ? 1 : 0;
    arm_start = 0;
    for (int i = 0; i < cyc_en.size(); i++) begin
      if (m_phase == 3) break;
      if (!cyc_en[i]) continue;
      x = cyc_din[i];
      m_written.push_back(x);
      if (m_phase == 0) begin
        if (m_written.size() == cfg_hp) begin m_phase = 1; arm_start = i + 1; end
      end else if (m_phase == 1) begin
        lvl = (use_r && rise && x >= cfg_level) || (use_f && fall && x <= cfg_level);
        tmo = (cfg_to != 0) && ((i - arm_start) >= cfg_to);
        if (lvl || tmo) begin
          m_trig  = m_written.size() - 1;
          m_flag  = lvl;
          m_phase = (LEN - cfg_hp - 1 == 0) ? 3 : 2;
        end else begin
          if (x < cfg_level - cfg_hyst) rise = 1;
          if (x > cfg_level + cfg_hyst) fall = 1;
        end
      end else begin
        post_n++;
        if (post_n == LEN - cfg_hp - 1) m_phase = 3;
      end
    end
  endtask

  task automatic readout(input string name);
    for (int k = 0; k < LEN; k++) exp_q.push_back(m_written[m_trig - cfg_hp + k]);
    got.delete();
    for (int k = 0; k < LEN; k++) begin
      rd = 1'b1; tick(); rd = 1'b0;
      if ($urandom_range(3, 0) == 0) tick();
    end
    @(negedge clk);
    for (int w = 0; w < 8 && exp_q.size() != 0; w++) @(negedge clk);
    check({name, " drained"}, exp_q.size(), 0);
    exp_q.delete();
    tick();
    rd = 1'b1; tick(); rd = 1'b0;
    @(negedge clk);
    check({name, " extra_rd_vld"}, dout_vld, 0);
  endtask

  task automatic acquire(input int mode, input int ncyc, input string name);
    do_start();
    drive_cycles(ncyc, mode);
    run_model();
    @(negedge clk);
    check({name, " busy"}, busy, (m_phase < 3));
    check({name, " done"}, done, (m_phase == 3));
    if (m_phase == 3) begin
      check({name, " trig_flag"}, trig_flag, m_flag);
      readout(name);
    end
  endtask

  initial begin
    per = 64; amp = 50;
    repeat (3) tick();
    @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset dout_vld", dout_vld, 0);
    check("reset trig_flag", trig_flag, 0);
    check("reset dout", $signed(dout), 0);
    tick(); rst = 1'b1; tick();
    rd = 1'b1; tick(); rd = 1'b0;
    @(negedge clk);
    check("idle rd vld", dout_vld, 0);

    // Ramp, rising edge through zero
    set_cfg(0, 0, 4, 100, 0);
    acquire(0, 1100, "t1_ramp");
    if (got.size() == LEN) begin
      check("t1 rec[100]", got[100], 0);
      check("t1 rec[0]", got[0], -100);
      check("t1 flag", trig_flag, 1);
    end

    // Sine, falling edge through 10
    per = 64;
    set_cfg(1, 10, 5, int'($urandom_range(900, 50)), 0);
    acquire(1, 2600, "t2_sine");
    if (got.size() == LEN) begin
      check("t2 trig<=level", got[cfg_hp] <= 10, 1);
      check("t2 pred>level", got[cfg_hp - 1] > 10, 1);
    end

    // Noise inside the hysteresis band, normal mode: never triggers
    set_cfg(0, 0, 8, 100, 0);
    acquire(2, 3000, "t3_noise");
    check("t3 busy", busy, 1);
    check("t3 done", done, 0);

    // Constant below level with timeout (start issued while busy)
    set_cfg(0, 20, 3, 100, 500);
    acquire(3, 2200, "t4_timeout");
    check("t4 done", done, 1);
    check("t4 flag", trig_flag, 0);

    // hpos beyond the record clamps to LEN-1; hpos=0 puts trigger first
    set_cfg(0, 0, 4, 1023, 0);
    acquire(0, 1300, "t5_hpmax");
    if (got.size() == LEN) check("t5 rec[LEN-1]", got[LEN-1], 0);
    set_cfg(0, 0, 4, 0, 0);
    acquire(0, 1200, "t5_hp0");
    if (got.size() == LEN) check("t5 rec[0]", got[0], 0);

    // Async reset during POST
    set_cfg(0, 0, 4, 100, 0);
    do_start();
    drive_cycles(300, 0);
    run_model();
    @(negedge clk);
    check("t6 busy before reset", busy, (m_phase < 3));
    #2 rst = 1'b0;
    #1;
    check("t6 rst busy", busy, 0);
    check("t6 rst done", done, 0);
    check("t6 rst dout_vld", dout_vld, 0);
    check("t6 rst trig_flag", trig_flag, 0);
    check("t6 rst dout", $signed(dout), 0);
    tick(); rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("t6 idle after reset done", done, 0);
    check("t6 idle after reset busy", busy, 0);

    // Start during ARM, then a fresh randomized acquisition restarts it
    set_cfg(0, 20, 3, 10, 0);
    do_start();
    drive_cycles(60, 3);
    @(negedge clk);
    check("t6 armed busy", busy, 1);
    amp = 100; per = 50;
    set_cfg(2, 0, 6, 300, 0);
    acquire(4, 3500, "t6_restart");

    // Randomized configurations
    for (int t = 0; t < 6; t++) begin
      amp = int'($urandom_range(120, 30));
      per = int'($urandom_range(100, 20));
      set_cfg(int'($urandom_range(3, 0)), int'($urandom_range(120, 0)) - 60,
              int'($urandom_range(20, 0)), int'($urandom_range(1023, 0)),
              ($urandom_range(1, 0) == 0) ? 0 : int'($urandom_range(1500, 1)));
      acquire(4, 3500, "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
